iram_dp: RTL
============

# iram_dp

Dual-port instruction RAM that replaces the fixed read-only instruction store feeding `seq_top`. Port A is a host port for loading kernels (write) and read-back; port B is the sequencer fetch port driven by `o_seq_pc_vld`/`o_seq_pc_offset`. The block is generalised in width, depth and read latency, locks host writes while a kernel runs, and carries a per-word parity bit that is checked on every fetch.

## Interface
- `DWIDTH`, default `INST_WIDTH`: instruction word width.
- `DEPTH`, default `IRAM_DEPTH`: number of words. Need not be a power of two.
- `AW`, default `$clog2(DEPTH)`: address width.
- `RD_DELAY`, default `COMMON_BRAM_DELAY`: read latency in cycles, must be ≥1. Applies to both ports.
- `CNT_W`, default 16: width of the write counter.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `i_wr_en`, in, 1: host write request.
- `i_wr_addr`, in, AW: host write address.
- `i_wr_data`, in, DWIDTH: host write data.
- `i_wr_lock`, in, 1: high while the sequencer runs; host writes are rejected.
- `i_hrd_en`, in, 1: host read request.
- `i_hrd_addr`, in, AW: host read address.
- `o_hrd_vld`, out, 1: host read data valid.
- `o_hrd_data`, out, DWIDTH: host read data.
- `o_hrd_drop`, out, 1: one-cycle pulse; a host read was dropped.
- `o_wr_rej`, out, 1: one-cycle pulse; a write was rejected (locked or out of range).
- `o_wr_cnt`, out, CNT_W: number of accepted writes, saturating.
- `i_wr_clr`, in, 1: clears `o_wr_cnt`.
- `rden`, in, 1: fetch request.
- `addr`, in, AW: fetch address.
- `o_vld`, out, 1: fetch data valid.
- `dout`, out, DWIDTH: fetch data.
- `o_perr`, out, 1: parity mismatch on the current fetch, qualified by `o_vld`.
- `o_oor`, out, 1: fetch address was ≥ DEPTH, qualified by `o_vld`.

## Operation
- **Storage.** Each word is stored as DWIDTH+1 bits: the data plus an even-parity bit computed when it is written. Memory contents are not reset.
- **Host write acceptance.** A write is accepted when `i_wr_en & ~i_wr_lock & (i_wr_addr < DEPTH)`. Otherwise `o_wr_rej` pulses on the next cycle and memory is unchanged.
- **Port A conflict.** Port A serves one access per cycle. If `i_wr_en` and `i_hrd_en` are high together, the write takes the port (whether it is accepted or rejected). The read is dropped: `o_hrd_drop` pulses on the next cycle and no `o_hrd_vld` is produced.
- **Write counter.** `o_wr_cnt` increments by 1 on each accepted write and saturates at 2^CNT_W−1. If `i_wr_clr` and an accepted write occur in the same cycle, clear wins and the result is 0.
- **Fetch.** Reads `{parity, data}` at `addr`.
  - Out-of-range address: `dout` = 0, `o_oor` = 1, `o_perr` = 0.
  - Otherwise: `o_perr` = XOR of the stored parity and the recomputed parity.
- **Same-address collision.** An accepted write and a fetch to the same address in the same cycle are read-first: the fetch returns the old word. A fetch issued one cycle later returns the new word.
- **Host read out of range.** Returns `o_hrd_data` = 0 with `o_hrd_vld` = 1.

## Timing
- **Fetch latency.** `rden` at edge t gives `o_vld`, `dout`, `o_perr` and `o_oor` at edge t+RD_DELAY. Back-to-back requests are accepted every cycle with no bubbles. Outputs keep request order.
- **Host read latency.** `i_hrd_en` at t (not dropped) gives `o_hrd_vld`/`o_hrd_data` at t+RD_DELAY.
- **Write timing.** Memory updates at the edge where `i_wr_en` is sampled. `o_wr_rej` and `o_hrd_drop` are registered and appear at t+1.
- **Reset values.** `o_vld`, `o_hrd_vld`, `o_hrd_drop`, `o_wr_rej`, `o_perr`, `o_oor` = 0; `dout`, `o_hrd_data` = 0; `o_wr_cnt` = 0.
- **Reset mid-operation.** All in-flight valids in both delay pipes are discarded, and no valid appears after reset deasserts until a new request arrives.
- **Data outputs.** `dout` and `o_hrd_data` keep their last value when the matching valid is low.

## Structure
- `INST_WIDTH`, `IRAM_DEPTH` and `COMMON_BRAM_DELAY` come from the shared `vp_defines.vh`/`common_defines.vh`. No new typedefs are added.
- Sub-module `bram_delay_pipe`: a parametrised RD_DELAY-stage shift register carrying `{vld, payload}` with async-reset valid bits. It is instanced once per port; the payload holds data, parity and the out-of-range flag.
- The memory array is inferred as true dual-port BRAM with read-first behaviour.

## Test plan
- **Load and fetch.** Write words 0..21 with `i_wr_data` = 0x1000+i and lock low. Then lock, and fetch addresses 0..21 back-to-back. Expect 22 `o_vld` pulses RD_DELAY cycles after each request, `dout` = 0x1000+i, `o_perr` = 0, and `o_wr_cnt` = 22.
- **Locked write.** Set `i_wr_lock` = 1 and write addr 5 = 0xDEAD. Expect `o_wr_rej` pulse, `o_wr_cnt` unchanged, and a later fetch of addr 5 returning 0x1005.
- **Read-first collision.** In the same cycle, write addr 7 = 0xBEEF and fetch addr 7. Expect `dout` = 0x1007. A fetch of addr 7 on the next cycle returns 0xBEEF.
- **Port A conflict.** Assert `i_wr_en` and `i_hrd_en` in the same cycle. Expect `o_hrd_drop` at t+1, no `o_hrd_vld`, and the write performed.
- **Parity and range.** Backdoor-flip data bit 0 of addr 3, then fetch addr 3: expect `o_perr` = 1. Fetch addr DEPTH (when DEPTH < 2^AW): expect `dout` = 0 and `o_oor` = 1.
- **Reset mid-fetch.** Issue 4 consecutive fetches, then drop `rst_n` for one cycle after 2 of them. Expect all outputs 0 during reset, no `o_vld` afterwards, and `o_wr_cnt` = 0.

Source files
------------

// File: rtl/iram_dp_pkg.sv
// rtl/iram_dp_pkg.sv - shared instruction-RAM sizing constants
package iram_dp_pkg;
   localparam int INST_WIDTH        = 32;
   localparam int IRAM_DEPTH        = 24;
   localparam int COMMON_BRAM_DELAY = 2;
endpackage

// File: rtl/bram_delay_pipe.sv
// rtl/bram_delay_pipe.sv - STAGES-deep {vld, payload} shift register, payload held while idle
module bram_delay_pipe #(
   parameter int STAGES = 1,
   parameter int PW     = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vld_i,
   input  logic [PW-1:0] payload_i,
   output logic          vld_o,
   output logic [PW-1:0] payload_o
);

   logic [STAGES-1:0] vld_q;
   logic [PW-1:0]     pay_q [STAGES];

   // Payload only advances behind a valid, so the last stage keeps the last delivered word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < STAGES; i++) pay_q[i] <= '0;
      end else begin
         vld_q[0] <= vld_i;
         if (vld_i) pay_q[0] <= payload_i;
         for (int i = 1; i < STAGES; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) pay_q[i] <= pay_q[i-1];
         end
      end
   end

   assign vld_o     = vld_q[STAGES-1];
   assign payload_o = pay_q[STAGES-1];

endmodule

// File: rtl/iram_dp.sv
// rtl/iram_dp.sv - dual-port instruction RAM: host load/read-back port and parity-checked fetch port
module iram_dp
   import iram_dp_pkg::*;
#(
   parameter int DWIDTH   = INST_WIDTH,
   parameter int DEPTH    = IRAM_DEPTH,
   parameter int AW       = $clog2(DEPTH),
   parameter int RD_DELAY = COMMON_BRAM_DELAY,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [DWIDTH-1:0] i_wr_data,
   input  logic              i_wr_lock,
   input  logic              i_hrd_en,
   input  logic [AW-1:0]     i_hrd_addr,
   output logic              o_hrd_vld,
   output logic [DWIDTH-1:0] o_hrd_data,
   output logic              o_hrd_drop,
   output logic              o_wr_rej,
   output logic [CNT_W-1:0]  o_wr_cnt,
   input  logic              i_wr_clr,
   input  logic              rden,
   input  logic [AW-1:0]     addr,
   output logic              o_vld,
   output logic [DWIDTH-1:0] dout,
   output logic              o_perr,
   output logic              o_oor
);

   localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

   logic [DWIDTH:0]     mem [DEPTH];
   logic                wr_acc;
   logic                a_req;
   logic [DWIDTH-1:0]   a_data;
   logic                b_oor;
   logic [DWIDTH:0]     b_word;
   logic                a_vld;
   logic [DWIDTH-1:0]   a_pay;
   logic                b_vld;
   logic [DWIDTH+1:0]   b_pay;
   logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
   logic                wr_rej_q, hrd_drop_q;

   assign wr_acc = i_wr_en & ~i_wr_lock & ({1'b0, i_wr_addr} < DEPTH_W);
   assign a_req  = i_hrd_en & ~i_wr_en;

   always_ff @(posedge clk) begin
      if (wr_acc) mem[i_wr_addr] <= {^i_wr_data, i_wr_data};
   end

   // Reads sample the array before this edge's write lands, giving read-first collisions.
   always_comb begin
      a_data = '0;
      if ({1'b0, i_hrd_addr} < DEPTH_W) a_data = mem[i_hrd_addr][DWIDTH-1:0];
      b_oor  = ~({1'b0, addr} < DEPTH_W);
      b_word = '0;
      if (!b_oor) b_word = mem[addr];
   end

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      if (i_wr_clr)                       wr_cnt_d = '0;
      else if (wr_acc && wr_cnt_q != '1)  wr_cnt_d = wr_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_q   <= '0;
         wr_rej_q   <= 1'b0;
         hrd_drop_q <= 1'b0;
      end else begin
         wr_cnt_q   <= wr_cnt_d;
         wr_rej_q   <= i_wr_en & ~wr_acc;
         hrd_drop_q <= i_hrd_en & i_wr_en;
      end
   end

   bram_delay_pipe #(.STAGES(RD_DELAY), .PW(DWIDTH)) u_pipe_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .vld_i     (a_req),
      .payload_i (a_data),
      .vld_o     (a_vld),
      .payload_o (a_pay)
   );

   bram_delay_pipe #(.STAGES(RD_DELAY), .PW(DWIDTH+2)) u_pipe_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .vld_i     (rden),
      .payload_i ({b_oor, b_word}),
      .vld_o     (b_vld),
      .payload_o (b_pay)
   );

   assign o_hrd_vld  = a_vld;
   assign o_hrd_data = a_pay;
   assign o_hrd_drop = hrd_drop_q;
   assign o_wr_rej   = wr_rej_q;
   assign o_wr_cnt   = wr_cnt_q;
   assign o_vld      = b_vld;
   assign dout       = b_pay[DWIDTH-1:0];
   assign o_perr     = b_vld & (b_pay[DWIDTH] ^ (^b_pay[DWIDTH-1:0]));
   assign o_oor      = b_vld & b_pay[DWIDTH+1];

endmodule
